// File: rtl/aes_encryption.sv
// aes_encryption: byte-serial AES-128 encryption core (10 rounds, one round per clock).
// Key and plaintext are shifted in one byte per cycle while load is high, the round
// keys are derived on the fly from the previous round key, and the ciphertext is
// shifted out one byte per cycle while ready is high.
// Optional build macro AES_ABORT_EN: enable=0 sampled during LOAD or ROUND aborts the
// operation and returns the core to IDLE (OUT is never aborted).
module aes_encryption (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_byte,
    input  logic [7:0] state_byte,
    input  logic       enable,
    output logic [7:0] state_out_byte,
    output logic       load,
    output logic       ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx  = {~b, 3'b000};
        sbox = SBOX_TABLE[idx +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [1:0]   fsm_r;
    logic [3:0]   cnt_r;
    logic [3:0]   round_r;
    logic [127:0] key_r;
    logic [127:0] data_r;
    logic [7:0]   out_r;
    logic         load_r;
    logic         ready_r;

    logic [7:0]   sub_s [16];
    logic [127:0] shifted_s;
    logic [127:0] mixed_s;
    logic [127:0] round_out_s;
    logic [31:0]  rot_word_s;
    logic [31:0]  sub_word_s;
    logic [31:0]  w4_s;
    logic [31:0]  w5_s;
    logic [31:0]  w6_s;
    logic [31:0]  w7_s;
    logic [127:0] round_key_s;
    logic         abort_s;

`ifdef AES_ABORT_EN
    assign abort_s = ~enable;
`else
    assign abort_s = 1'b0;
`endif

    // SubBytes: one S-box per state byte.
    for (genvar g = 0; g < 16; g++) begin : g_sub
        assign sub_s[g] = sbox(data_r[127-8*g -: 8]);
    end

    // ShiftRows: row r of column c takes the byte from column (c + r) mod 4.
    assign shifted_s = {sub_s[0],  sub_s[5],  sub_s[10], sub_s[15],
                        sub_s[4],  sub_s[9],  sub_s[14], sub_s[3],
                        sub_s[8],  sub_s[13], sub_s[2],  sub_s[7],
                        sub_s[12], sub_s[1],  sub_s[6],  sub_s[11]};

    assign mixed_s = {mix_column(shifted_s[127:96]), mix_column(shifted_s[95:64]),
                      mix_column(shifted_s[63:32]),  mix_column(shifted_s[31:0])};

    // Next round key from the current one; only the last word goes through the S-boxes.
    assign rot_word_s  = {key_r[23:0], key_r[31:24]};
    assign sub_word_s  = {sbox(rot_word_s[31:24]), sbox(rot_word_s[23:16]),
                          sbox(rot_word_s[15:8]),  sbox(rot_word_s[7:0])};
    assign w4_s        = key_r[127:96] ^ sub_word_s ^ {rcon(round_r), 24'h000000};
    assign w5_s        = key_r[95:64] ^ w4_s;
    assign w6_s        = key_r[63:32] ^ w5_s;
    assign w7_s        = key_r[31:0]  ^ w6_s;
    assign round_key_s = {w4_s, w5_s, w6_s, w7_s};

    // Final round skips MixColumns; every other round mixes before AddRoundKey.
    always_comb begin
        if (round_r == 4'd10) begin
            round_out_s = shifted_s ^ round_key_s;
        end else begin
            round_out_s = mixed_s ^ round_key_s;
        end
    end

    // Control FSM with byte/round counters, state and key registers, registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_r   <= ST_IDLE;
            cnt_r   <= 4'd0;
            round_r <= 4'd0;
            key_r   <= 128'd0;
            data_r  <= 128'd0;
            out_r   <= 8'd0;
            load_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    cnt_r   <= 4'd0;
                    round_r <= 4'd0;
                    out_r   <= 8'd0;
                    ready_r <= 1'b0;
                    if (enable) begin
                        fsm_r  <= ST_LOAD;
                        load_r <= 1'b1;
                    end else begin
                        load_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort_s) begin
                        fsm_r  <= ST_IDLE;
                        cnt_r  <= 4'd0;
                        load_r <= 1'b0;
                        key_r  <= 128'd0;
                        data_r <= 128'd0;
                    end else if (cnt_r == 4'd15) begin
                        // Last byte: complete K0 and apply the initial AddRoundKey.
                        key_r   <= {key_r[119:0], key_byte};
                        data_r  <= {data_r[119:0], state_byte} ^ {key_r[119:0], key_byte};
                        cnt_r   <= 4'd0;
                        round_r <= 4'd1;
                        load_r  <= 1'b0;
                        fsm_r   <= ST_ROUND;
                    end else begin
                        key_r  <= {key_r[119:0], key_byte};
                        data_r <= {data_r[119:0], state_byte};
                        cnt_r  <= cnt_r + 4'd1;
                    end
                end
                ST_ROUND: begin
                    if (abort_s) begin
                        fsm_r   <= ST_IDLE;
                        cnt_r   <= 4'd0;
                        round_r <= 4'd0;
                        key_r   <= 128'd0;
                        data_r  <= 128'd0;
                    end else begin
                        data_r <= round_out_s;
                        key_r  <= round_key_s;
                        if (round_r == 4'd10) begin
                            // Present the first ciphertext byte together with ready.
                            fsm_r   <= ST_OUT;
                            round_r <= 4'd0;
                            cnt_r   <= 4'd0;
                            ready_r <= 1'b1;
                            out_r   <= round_out_s[127:120];
                        end else begin
                            round_r <= round_r + 4'd1;
                        end
                    end
                end
                ST_OUT: begin
                    if (cnt_r == 4'd15) begin
                        fsm_r   <= ST_IDLE;
                        cnt_r   <= 4'd0;
                        ready_r <= 1'b0;
                        out_r   <= 8'd0;
                        data_r  <= 128'd0;
                        key_r   <= 128'd0;
                    end else begin
                        cnt_r  <= cnt_r + 4'd1;
                        out_r  <= data_r[119:112];
                        data_r <= {data_r[119:0], 8'h00};
                    end
                end
                default: begin
                    fsm_r   <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    round_r <= 4'd0;
                    out_r   <= 8'd0;
                    load_r  <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign state_out_byte = out_r;
    assign load           = load_r;
    assign ready          = ready_r;

endmodule

// File: tb/tb_aes_encryption.sv
// tb_aes_encryption: known-answer and random vectors against a byte-array AES-128 model.
module tb_aes_encryption;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_byte;
    logic [7:0] state_byte;
    logic       enable;
    logic [7:0] state_out_byte;
    logic       load;
    logic       ready;

    aes_encryption dut (
        .clk           (clk),
        .rst           (rst),
        .key_byte      (key_byte),
        .state_byte    (state_byte),
        .enable        (enable),
        .state_out_byte(state_out_byte),
        .load          (load),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sbox_tab [256];
    logic [7:0] kq[$];
    logic [7:0] pq[$];
    logic [7:0] ctq[$];
    int         load_rise[$];
    int         load_fall[$];
    int         ready_rise[$];
    int         ready_fall[$];
    int         cyc;
    int         fed;
    int         drop_at;
    int         release_after;
    logic       prev_load;
    logic       prev_ready;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;
    vec_t tbl [6];

    localparam logic [127:0] KEY_A = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] PT_A  = 128'h54776F204F6E65204E696E652054776F;
    localparam logic [127:0] CT_A  = 128'h29C3505F571420F6402299B31A02D73A;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] CT_B  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse found by search, then affine map.
    task automatic init_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [7:0]   t0;
        logic [127:0] kk;
        logic [127:0] pp;
        logic [127:0] res;
        kk = key;
        pp = pt;
        for (int i = 0; i < 16; i++) begin
            w[i] = kk[127:120];
            s[i] = pp[127:120];
            kk = kk << 8;
            pp = pp << 8;
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                t0 = tmp[0];
                tmp[0] = sbox_tab[tmp[1]] ^ rc;
                tmp[1] = sbox_tab[tmp[2]];
                tmp[2] = sbox_tab[tmp[3]];
                tmp[3] = sbox_tab[t0];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r+4*c] = sbox_tab[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        res = 128'd0;
        for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
        return res;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1000;
    endfunction

    function automatic logic [127:0] ct_word(input int base);
        logic [127:0] res;
        res = 128'd0;
        for (int i = 0; i < 16; i++) begin
            if (base + i < ctq.size()) res = {res[119:0], ctq[base+i]};
            else res = {res[119:0], 8'h00};
        end
        return res;
    endfunction

    task automatic clear_trace();
        kq.delete(); pq.delete(); ctq.delete();
        load_rise.delete(); load_fall.delete(); ready_rise.delete(); ready_fall.delete();
        cyc = 0;
        fed = 0;
        drop_at = -1;
        release_after = 99;
        prev_load = load;
        prev_ready = ready;
    endtask

    task automatic push_bytes(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] kk;
        logic [127:0] pp;
        kk = key;
        pp = pt;
        for (int i = 0; i < 16; i++) begin
            kq.push_back(kk[127:120]);
            pq.push_back(pp[127:120]);
            kk = kk << 8;
            pp = pp << 8;
        end
    endtask

    // One clock: sample at the falling edge, log phase edges, feed bytes while load is high.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (load && !prev_load)   load_rise.push_back(cyc);
        if (!load && prev_load)   load_fall.push_back(cyc);
        if (ready && !prev_ready) ready_rise.push_back(cyc);
        if (!ready && prev_ready) ready_fall.push_back(cyc);
        prev_load  = load;
        prev_ready = ready;
        if (ready) ctq.push_back(state_out_byte);
        if (ready_rise.size() >= release_after) enable = 1'b0;
        if (load) begin
            if (kq.size() > 0) key_byte = kq.pop_front(); else key_byte = 8'($urandom);
            if (pq.size() > 0) state_byte = pq.pop_front(); else state_byte = 8'($urandom);
            if (fed == drop_at) enable = 1'b0;
            fed++;
        end else begin
            key_byte   = 8'($urandom);
            state_byte = 8'($urandom);
        end
    endtask

    task automatic run_single(input logic [127:0] key, input logic [127:0] pt,
                              input logic [127:0] exp, input int drop, input string nm);
        clear_trace();
        push_bytes(key, pt);
        drop_at = drop;
        release_after = 1;
        enable = 1'b1;
        for (int i = 0; i < 80 && ready_fall.size() == 0; i++) tick();
        check_int({nm, "_load_start"}, at(load_rise, 0), 1);
        check_int({nm, "_load_len"}, at(load_fall, 0) - at(load_rise, 0), 16);
        check_int({nm, "_round_gap"}, at(ready_rise, 0) - at(load_fall, 0), 10);
        check_int({nm, "_ready_len"}, at(ready_fall, 0) - at(ready_rise, 0), 16);
        check({nm, "_ct"}, ct_word(0), exp);
        check_int({nm, "_out_idle"}, int'(state_out_byte), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        key_byte = 8'h00;
        state_byte = 8'h00;
        init_sbox();
        #3;
        check("reset_outputs", 128'({state_out_byte, load, ready}), 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_trace();
        repeat (5) tick();
        check_int("idle_no_load", load_rise.size(), 0);

        check("model_vecA", aes_ref(KEY_A, PT_A), CT_A);
        check("model_vecB", aes_ref(KEY_B, PT_B), CT_B);

        tbl[0] = '{key: KEY_A, pt: PT_A, ct: CT_A};
        tbl[1] = '{key: KEY_B, pt: PT_B, ct: CT_B};
        for (int i = 2; i < 6; i++) begin
            tbl[i].key = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            tbl[i].ct  = aes_ref(tbl[i].key, tbl[i].pt);
        end
        for (int i = 0; i < 6; i++) run_single(tbl[i].key, tbl[i].pt, tbl[i].ct, -1, $sformatf("vec%0d", i));

`ifdef AES_ABORT_EN
        clear_trace();
        push_bytes(KEY_A, PT_A);
        drop_at = 8;
        enable = 1'b1;
        repeat (50) tick();
        check_int("abort_no_ready", ready_rise.size(), 0);
        check_int("abort_load_len", at(load_fall, 0) - at(load_rise, 0), 9);
        run_single(KEY_A, PT_A, CT_A, -1, "abort_restart");
`else
        run_single(KEY_A, PT_A, CT_A, 8, "enable_ignored");
`endif

        // Back-to-back: enable held high across two operations.
        clear_trace();
        push_bytes(KEY_A, PT_A);
        push_bytes(KEY_B, PT_B);
        release_after = 2;
        enable = 1'b1;
        for (int i = 0; i < 160 && ready_fall.size() < 2; i++) tick();
        check("b2b_ctA", ct_word(0), CT_A);
        check("b2b_ctB", ct_word(16), CT_B);
        check_int("b2b_reload", at(load_rise, 1) - at(ready_fall, 0), 1);
        check_int("b2b_load_len2", at(load_fall, 1) - at(load_rise, 1), 16);
        check_int("b2b_ready_len2", at(ready_fall, 1) - at(ready_rise, 1), 16);

        // Asynchronous reset in the middle of the round phase.
        clear_trace();
        push_bytes(KEY_A, PT_A);
        enable = 1'b1;
        for (int i = 0; i < 40 && load_fall.size() == 0; i++) tick();
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check("rst_round_outputs", 128'({state_out_byte, load, ready}), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset while ciphertext is streaming.
        clear_trace();
        push_bytes(KEY_B, PT_B);
        enable = 1'b1;
        for (int i = 0; i < 60 && ready_rise.size() == 0; i++) tick();
        repeat (2) tick();
        check_int("pre_rst_ready", int'(ready), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_out_outputs", 128'({state_out_byte, load, ready}), 128'd0);
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        clear_trace();
        repeat (40) tick();
        check_int("post_rst_no_load", load_rise.size(), 0);
        check_int("post_rst_no_ready", ready_rise.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
